// File: rtl/tt_sel_ctrl.sv
// rtl/tt_sel_ctrl.sv - user-module select controller: pad sync, inc/serial load, wrap, range check, ena blanking
// Address ordering is row-major with bottom/top tiles interleaved, so row/col are plain bit slices.
module tt_sel_ctrl #(
    parameter int G_X         = 16,
    parameter int G_Y         = 24,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4,
    localparam int N_MOD      = G_X * G_Y,
    localparam int AW         = $clog2(N_MOD),
    localparam int CW         = $clog2(2 * G_X),
    localparam int RW         = AW - CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_sel_rst_n,
    input  logic          ctrl_sel_inc,
    input  logic          ctrl_sel_load,
    input  logic          ctrl_sel_dat,
    input  logic          ctrl_ena,
    output logic [AW-1:0] sel_addr,
    output logic [RW-1:0] sel_row,
    output logic [CW-1:0] sel_col,
    output logic          um_ena,
    output logic          busy,
    output logic          sel_err
);

    localparam logic [AW:0]   N_MOD_W  = (AW + 1)'(N_MOD);
    localparam logic [AW-1:0] LAST     = AW'(N_MOD - 1);
    localparam logic [7:0]    SETTLE_W = 8'(SETTLE);

    typedef enum logic {S_RUN, S_SETTLE} state_t;

    logic [SYNC_STAGES-1:0] s_rst_n, s_inc, s_load, s_dat, s_ena;
    logic                   inc_d, load_d;
    logic [AW-1:0]          shreg;
    logic [AW-1:0]          addr_next, shreg_next;
    logic                   err_next;
    logic                   addr_chg;
    state_t                 state, state_next;
    logic [7:0]             cnt, cnt_next;
    logic                   um_ena_next;

    wire rst_n_s   = s_rst_n[SYNC_STAGES-1];
    wire inc_s     = s_inc[SYNC_STAGES-1];
    wire load_s    = s_load[SYNC_STAGES-1];
    wire dat_s     = s_dat[SYNC_STAGES-1];
    wire ena_s     = s_ena[SYNC_STAGES-1];
    wire inc_rise  = inc_s & ~inc_d;
    wire load_fall = ~load_s & load_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rst_n <= '0;
            s_inc   <= '0;
            s_load  <= '0;
            s_dat   <= '0;
            s_ena   <= '0;
            inc_d   <= 1'b0;
            load_d  <= 1'b0;
        end else begin
            s_rst_n <= {s_rst_n[SYNC_STAGES-2:0], ctrl_sel_rst_n};
            s_inc   <= {s_inc[SYNC_STAGES-2:0], ctrl_sel_inc};
            s_load  <= {s_load[SYNC_STAGES-2:0], ctrl_sel_load};
            s_dat   <= {s_dat[SYNC_STAGES-2:0], ctrl_sel_dat};
            s_ena   <= {s_ena[SYNC_STAGES-2:0], ctrl_ena};
            inc_d   <= inc_s;
            load_d  <= load_s;
        end
    end

    // Load falling edge outranks a coincident inc edge, which is simply dropped.
    always_comb begin
        addr_next  = sel_addr;
        shreg_next = shreg;
        err_next   = sel_err;
        if (!rst_n_s) begin
            addr_next  = '0;
            shreg_next = '0;
            err_next   = 1'b0;
        end else if (load_fall) begin
            if ({1'b0, shreg} < N_MOD_W)
                addr_next = shreg;
            else
                err_next = 1'b1;
            shreg_next = '0;
        end else if (inc_rise && load_s) begin
            shreg_next = {shreg[AW-2:0], dat_s};
        end else if (inc_rise) begin
            addr_next = (sel_addr == LAST) ? '0 : sel_addr + AW'(1);
        end
    end

    assign addr_chg = (addr_next != sel_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_addr <= '0;
            shreg    <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_addr <= addr_next;
            shreg    <= shreg_next;
            sel_err  <= err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_SETTLE;
            cnt    <= SETTLE_W;
            um_ena <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            um_ena <= um_ena_next;
        end
    end

    // Any real address change (re)starts the blanking window, even mid-window.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (addr_chg) begin
            state_next = S_SETTLE;
            cnt_next   = SETTLE_W;
        end else if (state == S_SETTLE) begin
            if (cnt == 8'd1)
                state_next = S_RUN;
            else
                cnt_next = cnt - 8'd1;
        end
    end

    always_comb begin
        um_ena_next = (state_next == S_RUN) && ena_s;
        busy        = (state == S_SETTLE);
    end

    assign sel_row = sel_addr[AW-1:CW];
    assign sel_col = sel_addr[CW-1:0];

endmodule

// File: doc/tt_sel_ctrl.md
Name: tt_sel_ctrl

Overview:
- Parametrised user-module selection controller; next generation of the pad-driven select/increment/enable control feeding the spine and row muxes.
- Synchronises the async control pads and keeps the selected-module address.
- Adds a serial address-load mode, wrap-around at the real module count, range checking, and a timed enable blanking window after each address change, so a module never sees `ena` while the muxes are switching.

Parameters:
- G_X, 16, user-module columns per row; must be a power of two.
- G_Y, 24, user-module rows; must be even.
- SYNC_STAGES, 2, synchroniser flops per control input; minimum 2.
- SETTLE, 4, `um_ena` blanking cycles after any address change; range 1..255.
- Derived localparams: N_MOD = G_X*G_Y; AW = $clog2(N_MOD) (9 at defaults).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ctrl_sel_rst_n  in  1  async pad; low clears the address
- ctrl_sel_inc  in  1  async pad; rising edge steps the address, or shifts a bit in load mode
- ctrl_sel_load  in  1  async pad; high selects serial-load mode
- ctrl_sel_dat  in  1  async pad; serial address data, MSB first
- ctrl_ena  in  1  async pad; global user-module enable request
- sel_addr  out  AW  selected module, linear index; ordering is row-major with bottom/top interleaved: addr = (y>>1)*2*G_X + 2*x + (y&1)
- sel_row  out  AW-log2(2*G_X)  sel_addr / (2*G_X)
- sel_col  out  log2(2*G_X)  sel_addr % (2*G_X)
- um_ena  out  1  enable to the selected module
- busy  out  1  high during the blanking window
- sel_err  out  1  sticky; an out-of-range serial load was rejected

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high. On reset:
  - all synchroniser flops clear to 0;
  - sel_addr=0, shift register=0, sel_err=0;
  - state=SETTLE with counter=SETTLE, so um_ena=0 and busy=1.
- Synchronisers: every ctrl_* input passes through SYNC_STAGES flops. Edges are detected by one further register on the synced sel_inc and sel_load.
- Latency: a pad change produces its effect on the (SYNC_STAGES+1)-th rising clk edge after the change is first sampled (3 at default).
- Address-update priority, evaluated once per cycle:
  1. Synced sel_rst_n low: sel_addr<=0. Pending shift data is discarded: shreg<=0 and the bit count is cleared. Edges on inc and on load's falling edge are ignored.
  2. Else, falling edge of synced load: if shreg < N_MOD, sel_addr<=shreg; otherwise sel_addr is unchanged and sel_err<=1. In both cases shreg<=0.
  3. Else, rising edge of synced inc while synced load is high: shreg <= {shreg[AW-2:0], synced dat}. Bits beyond AW shift out and are lost.
  4. Else, rising edge of synced inc while load is low: sel_addr <= (sel_addr==N_MOD-1) ? 0 : sel_addr+1.
- Simultaneous inc edge and load falling edge: the load wins; the inc edge is dropped.
- sel_err is cleared only by `rst` or by the sel_rst_n clear.
- "Address change" means any cycle in which the sel_addr register is written with a value different from its current value. A load of the same value, or a clear while already 0, does not count.
- State machine, two states:
  - RUN: um_ena = synced ctrl_ena; busy=0. On an address change: go to SETTLE, counter<=SETTLE, um_ena=0 from the same edge that updates sel_addr.
  - SETTLE: um_ena=0, busy=1; counter decrements each cycle. When the counter reaches 1, go to RUN on the next edge.
  - An address change while in SETTLE reloads the counter to SETTLE (restart).
- Exact blanking: after the final address change, um_ena is low for exactly SETTLE cycles before following ctrl_ena again.
- sel_row and sel_col are combinational bit slices of sel_addr; there are no additional registers on them.
- Reset mid-operation: `rst` asserted during SETTLE or during a shift sequence aborts immediately to the reset values above.
- Outputs are registered except sel_row and sel_col.

Test Plan:
- Reset, then ctrl_ena=1 with pads idle (sel_rst_n=1) → sel_addr=0, um_ena=0 and busy=1 for 4 cycles after reset release, then um_ena=1.
- Issue 5 inc pulses, each ≥4 cycles apart → sel_addr 1..5; sel_row=0, sel_col=5. um_ena drops on each step and reasserts 4 cycles after the last step. Measured pin-to-address latency = 3 cycles.
- Serial load of 383 (9'h17F): load=1, then 9 inc pulses presenting 1,0,1,1,1,1,1,1,1; then load=0 → sel_addr=383, sel_row=11, sel_col=31, sel_err=0. One further inc → sel_addr wraps to 0.
- Serial load of 400 → sel_addr unchanged, sel_err=1, no blanking window. Then sel_rst_n=0 → sel_addr=0, sel_err=0.
- Second inc arriving 2 cycles into a SETTLE window → counter restarts; um_ena stays low for 4 cycles after the second change (6 total).
- Assert rst mid-shift after 4 bits, release, then pulse load alone → sel_addr=0, shreg=0, no error.
